// File: rtl/hack_pkg.sv
// Shared definitions for the word-oriented memory blocks.
//   WORD_W      : default data word width
//   RAM8_DEPTH  : number of words in one ram8_word
//   RAM8_AW     : address width needed to select one of RAM8_DEPTH words
//   word_t      : one data word of WORD_W bits
package hack_pkg;

    localparam int WORD_W     = 16;
    localparam int RAM8_DEPTH = 8;
    localparam int RAM8_AW    = 3;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/ram8_word_reg.sv
// word_reg: one WIDTH-bit storage word with synchronous clear and load enable.
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous active-high clear, wins over load
//   in   in   WIDTH  data to store
//   load in   1      store enable, sampled at the rising edge
//   out  out  WIDTH  stored word
module word_reg
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else if (load) begin
            r_word <= in;
        end
    end

    assign out = r_word;

endmodule

// File: rtl/ram8_word.sv
// ram8_word: eight-word memory, synchronous write, combinational read.
// The load strobe is steered one-hot to a single word_reg; the addressed word
// is selected back out through an 8-way mux.
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high clear of all eight words
//   in      in   WIDTH  write data
//   load    in   1      write strobe, sampled at the rising edge
//   address in   3      word select for both write and read
//   out     out  WIDTH  read data for address
// Build option:
//   RAM8_WRITE_THROUGH_EN - when defined, out bypasses to in while load=1, and
//   is forced to 0 while rst=1, in the same cycle. Undefined: out always shows
//   the stored word, so a write becomes visible only after the edge.
module ram8_word
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic               load,
    input  logic [RAM8_AW-1:0] address,
    output logic [WIDTH-1:0]   out
);

    logic [RAM8_DEPTH-1:0] w_load_onehot;
    logic [WIDTH-1:0]      w_words [RAM8_DEPTH];
    logic [WIDTH-1:0]      w_rd_word;

    // Write decode: exactly one strobe bit when load=1, none otherwise.
    always_comb begin
        w_load_onehot = '0;
        if (load) begin
            w_load_onehot[address] = 1'b1;
        end
    end

    for (genvar g = 0; g < RAM8_DEPTH; g++) begin : g_word
        word_reg #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk (clk),
            .rst (rst),
            .in  (in),
            .load(w_load_onehot[g]),
            .out (w_words[g])
        );
    end

    // Read select.
    always_comb begin
        w_rd_word = w_words[address];
    end

`ifdef RAM8_WRITE_THROUGH_EN
    // Same-cycle view of what the addressed word is about to become.
    always_comb begin
        if (rst) begin
            out = '0;
        end else if (load) begin
            out = in;
        end else begin
            out = w_rd_word;
        end
    end
`else
    assign out = w_rd_word;
`endif

endmodule
